// File: rtl/cnt_sched_pkg.sv
// cnt_sched shared types: FSM states and the round-robin one-hot pick.
// Imported by the scheduler top and its counter.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int MAX_N = 32;

  // First valid bit at or after ptr, wrapping below n; zero if none.
  function automatic logic [MAX_N-1:0] rr_pick(
    input logic [MAX_N-1:0] valid,
    input int               ptr,
    input int               n
  );
    int hi;
    int lo;
    logic has_hi;
    logic has_lo;
    hi = 0;
    lo = 0;
    has_hi = 1'b0;
    has_lo = 1'b0;
    for (int j = MAX_N - 1; j >= 0; j--) begin
      if (j < n && valid[j]) begin
        if (j >= ptr) begin
          hi = j;
          has_hi = 1'b1;
        end else begin
          lo = j;
          has_lo = 1'b1;
        end
      end
    end
    if (has_hi) begin
      return MAX_N'(1) << hi;
    end else if (has_lo) begin
      return MAX_N'(1) << lo;
    end
    return '0;
  endfunction

endpackage

// File: rtl/cnt_sched_cnt.sv
// Threshold counter: counts while enabled, flags tc at thr and wraps.
// clr has priority over en.
module cnt_sched_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] thr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tc_o  = en_i & (cnt_q == thr_i);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one threshold counter among N requesters.
// Optional abort support under `CNT_SCHED_ABORT_EN.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_valid_i,
  output logic [N-1:0]     req_ready_o,
  input  logic [N*W-1:0]   req_dly_i,
  output logic [N-1:0]     done_o,
  output logic             busy_o,
  output logic [IDW-1:0]   cur_id_o,
  output logic [W-1:0]     elapsed_o
`ifdef CNT_SCHED_ABORT_EN
  ,
  input  logic             abort_i,
  output logic             aborted_o
`endif
);

  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [W-1:0] thr_q, thr_d;

  logic [MAX_N-1:0] gnt_full;
  logic [N-1:0] gnt;
  logic [IDW-1:0] win;
  logic any;

  logic cnt_en;
  logic cnt_clr;
  logic tc;
  logic [W-1:0] cnt_val;

`ifdef CNT_SCHED_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  always_comb begin
    gnt_full = rr_pick(MAX_N'(req_valid_i), int'(ptr_q), N);
    gnt = gnt_full[N-1:0];
    any = |gnt_full;
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        win = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cur_id_d = cur_id_q;
    thr_d = thr_q;
    cnt_en = 1'b0;
    cnt_clr = 1'b0;
    req_ready_o = '0;
    done_o = '0;
`ifdef CNT_SCHED_ABORT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready_o = gnt;
        if (any) begin
          thr_d = req_dly_i[win*W +: W];
          cur_id_d = win;
          cnt_clr = 1'b1;
          ptr_d = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
`ifdef CNT_SCHED_ABORT_EN
        // Abort beats a coincident tc.
        if (abort_i) begin
          cnt_clr = 1'b1;
          aborted_d = 1'b1;
          state_d = IDLE;
        end else if (tc) begin
          state_d = DONE;
        end
`else
        if (tc) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        done_o[cur_id_q] = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cur_id_q <= '0;
      thr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cur_id_q <= cur_id_d;
      thr_q <= thr_d;
    end
  end

`ifdef CNT_SCHED_ABORT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted_o = aborted_q;
`endif

  cnt_sched_cnt #(
    .W(W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .thr_i (thr_q),
    .cnt_o (cnt_val),
    .tc_o  (tc)
  );

  assign busy_o = (state_q != IDLE);
  assign cur_id_o = cur_id_q;
  assign elapsed_o = cnt_val;

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched: a cycle-level job model predicts grants,
// busy/elapsed, and queues expected done pulses for a separate monitor.
module tb_cnt_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] req_valid_i;
  logic [N-1:0] req_ready_o;
  logic [N*W-1:0] req_dly_i;
  logic [N-1:0] done_o;
  logic busy_o;
  logic [1:0] cur_id_o;
  logic [W-1:0] elapsed_o;
`ifdef CNT_SCHED_ABORT_EN
  logic abort_i;
  logic aborted_o;
`endif

  cnt_sched #(
    .N(N),
    .W(W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_dly_i  (req_dly_i),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .cur_id_o   (cur_id_o),
    .elapsed_o  (elapsed_o)
`ifdef CNT_SCHED_ABORT_EN
    ,
    .abort_i    (abort_i),
    .aborted_o  (aborted_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int id;
    int due;
  } exp_t;
  exp_t q[$];
  bit mon_en = 1'b0;

  // Model state: job timing in absolute cycles.
  int m_ptr, m_free, m_acc, m_d, m_id, m_abort_due;
  bit m_act;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      exp_t e;
      if (q.size() > 0 && q[0].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_missing cyc=%0d got=none exp=id%0d@%0d",
                 cyc, q[0].id, q[0].due);
        void'(q.pop_front());
      end
      if (done_o != '0) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected cyc=%0d got=%b exp=0000", cyc, done_o);
        end else begin
          e = q.pop_front();
          chk("done_id", longint'(done_o), longint'(1) << e.id);
          chk("done_cyc", cyc, e.due);
        end
      end
    end
  end

  task automatic set_req(input int i, input int d);
    req_valid_i[i] = 1'b1;
    req_dly_i[i*W +: W] = W'(d);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_id = 0;
    m_act = 1'b0;
    m_acc = 0;
    m_d = 0;
    m_abort_due = -1;
  endtask

  // One clock: check DUT against model at negedge, then advance.
  task automatic step();
    int w;
    int c;
    int d;
    logic [N-1:0] er;
    @(negedge clk_i);
    c = cyc;
    w = -1;
    er = '0;
    if (c >= m_free) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && req_valid_i[j]) w = j;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    chk("ready", req_ready_o, er);
    chk("busy", busy_o, m_act && c > m_acc && c <= m_acc + m_d + 2);
    chk("elapsed", elapsed_o,
        (m_act && c > m_acc && c <= m_acc + m_d + 1) ? c - m_acc - 1 : 0);
    chk("cur_id", cur_id_o, m_id);
`ifdef CNT_SCHED_ABORT_EN
    chk("aborted", aborted_o, m_abort_due == c);
    if (abort_i && m_act && c > m_acc && c <= m_acc + m_d + 1) begin
      void'(q.pop_back());
      m_act = 1'b0;
      m_free = c + 1;
      m_abort_due = c + 1;
    end
`endif
    if (w >= 0) begin
      d = int'(req_dly_i[w*W +: W]);
      q.push_back('{w, c + d + 2});
      m_acc = c;
      m_d = d;
      m_act = 1'b1;
      m_id = w;
      m_ptr = (w + 1) % N;
      m_free = c + d + 3;
    end
    @(posedge clk_i);
    #1;
    if (w >= 0) req_valid_i[w] = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_elapsed"}, elapsed_o, 0);
    chk({tag, "_cur_id"}, cur_id_o, 0);
  endtask

  initial begin
    req_valid_i = '0;
    req_dly_i = '0;
`ifdef CNT_SCHED_ABORT_EN
    abort_i = 1'b0;
`endif
    model_reset();
    m_free = 0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero_outputs("rst");
    rst_ni = 1'b1;
    m_free = cyc;
    mon_en = 1'b1;

    // Single job, D=5.
    set_req(0, 5);
    repeat (10) step();

    // Zero delay on requester 2.
    set_req(2, 0);
    repeat (5) step();

    // All requesters continuously valid with D=1.
    repeat (24) begin
      for (int i = 0; i < N; i++) set_req(i, 1);
      step();
    end
    req_valid_i = '0;
    repeat (6) step();

    // Withdraw: req1 pulses valid while req0 runs.
    set_req(0, 10);
    step();
    set_req(1, 3);
    step();
    req_valid_i[1] = 1'b0;
    repeat (14) step();
    set_req(1, 2);
    set_req(3, 2);
    repeat (16) step();

    // Async reset in the middle of a long job.
    set_req(3, 100);
    repeat (40) step();
    #2;
    rst_ni = 1'b0;
    req_valid_i = '0;
    #1;
    chk_zero_outputs("arst");
    mon_en = 1'b0;
    q.delete();
    model_reset();
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m_free = cyc;
    mon_en = 1'b1;
    repeat (110) step();
    for (int i = 0; i < N; i++) set_req(i, 2);
    repeat (6) step();
    req_valid_i = '0;
    repeat (6) step();

`ifdef CNT_SCHED_ABORT_EN
    // Abort a D=50 job after 10 cycles; a new request follows at once.
    set_req(1, 50);
    repeat (10) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    set_req(2, 3);
    repeat (10) step();
`endif

    // Random traffic with withdrawals.
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i]) begin
          if ($urandom_range(7) == 0) begin
            if ($urandom_range(4) == 0) set_req(i, int'($urandom_range(40)));
            else set_req(i, int'($urandom_range(5)));
          end
        end else if ($urandom_range(39) == 0) begin
          req_valid_i[i] = 1'b0;
        end
      end
`ifdef CNT_SCHED_ABORT_EN
      abort_i = ($urandom_range(29) == 0);
`endif
      step();
    end
`ifdef CNT_SCHED_ABORT_EN
    abort_i = 1'b0;
`endif
    req_valid_i = '0;
    repeat (60) step();
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Round-robin scheduler that shares one threshold counter (the team's `cnt` block) among N requesters.
- Each requester submits a delay value through a valid/ready handshake.
- The scheduler loads the delay as the counter threshold, runs the counter, and pulses a per-requester done when the threshold is reached.
- Sits between software-visible timer request ports and the single hardware counter instance.

Parameters:
- N, 4, number of requesters (≥2).
- W, 16, counter/delay bitwidth.
- IDW, $clog2(N), derived localparam, width of requester index; not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  N  per-requester request valid
- req_ready_o  out  N  per-requester grant/accept, at most one bit high
- req_dly_i  in  N*W  packed delays; slice i belongs to requester i
- done_o  out  N  one-cycle completion pulse to the owning requester
- busy_o  out  1  high in RUN and DONE
- cur_id_o  out  IDW  index of the active requester; holds last value when idle
- elapsed_o  out  W  current counter value
- abort_i  in  1  only with CNT_SCHED_ABORT_EN
- aborted_o  out  1  only with CNT_SCHED_ABORT_EN

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. On reset:
  - state IDLE, rr pointer = 0, cur_id_o = 0, latched threshold = 0;
  - all outputs 0, counter cleared.
  - Reset mid-RUN abandons the job silently; no done_o.
- FSM states: IDLE, RUN, DONE (enum in package).
- IDLE:
  - Combinational round-robin pick among req_valid_i, starting at the pointer.
  - req_ready_o[winner] = 1 in the same cycle; no other ready bit is set.
  - Acceptance occurs when valid and ready are both high. On acceptance:
    - latch thr = req_dly_i[winner] and cur_id = winner;
    - counter clr = 1;
    - pointer <= (winner+1) mod N;
    - next state RUN.
  - With no valid request, stay in IDLE; counter en = 0.
- RUN:
  - Counter en = 1, thr = latched value; req_ready_o = 0.
  - When counter tc = 1 (cnt == thr), go to DONE; the counter wraps to 0 itself.
- DONE:
  - done_o[cur_id] = 1 for exactly one cycle.
  - Counter en = 0; next state IDLE.
  - No grant is issued in this cycle.
- Latency:
  - Acceptance in cycle 0 → RUN cycles 1..D+1 → done_o in cycle D+2, where D = delay.
  - D = 0 gives done in cycle 2.
  - Back-to-back jobs: next acceptance is possible no earlier than cycle D+3.
- Requester rules:
  - req_valid_i must stay high with a stable delay until ready is seen; the scheduler never samples an un-accepted request.
  - Deasserting valid before grant is allowed and simply withdraws the request.
- Fairness: any continuously valid requester is granted within N jobs.
- Widths:
  - D = 2^W−1 is legal; the counter never overflows because tc fires at the maximum value.
  - elapsed_o equals the counter value; it is 0 in IDLE after completion.
- Simultaneous events: a requester whose done_o is pulsing may reassert valid; it is arbitrated in the following IDLE cycle like any other request.

Optional Feature:
- Macro: CNT_SCHED_ABORT_EN.
- When defined, abort_i and aborted_o exist.
  - abort_i = 1 in RUN: counter clr = 1, next state IDLE, no done_o.
  - aborted_o pulses for one cycle (the IDLE cycle after RUN).
  - The pointer is unaffected.
  - abort_i in IDLE or DONE is ignored; DONE completes normally.
  - If abort_i and tc occur in the same cycle, abort wins.
- When undefined: no ports, no abort logic; RUN exits only on tc.

Decomposition:
- Package cnt_sched_pkg: state_e typedef (IDLE, RUN, DONE) and a function for the round-robin one-hot pick from (valid, pointer).
- Sub-module: a single instance of `cnt` (W parameter passed through), driven by en/clr/thr from the FSM.
- Arbitration stays inline; a separate arbiter module is unnecessary at this size.

Test Plan:
- Single job: N=4, W=16, req0 valid with D=5 at cycle 0 → ready[0] at cycle 0, done_o=0001 at cycle 7, busy_o high for cycles 1–7.
- Zero delay: req2 with D=0 → done_o=0100 at cycle 2; elapsed_o=0 throughout.
- Round-robin: all four valid continuously with D=1 → grant order 0,1,2,3,0; one grant every 4 cycles; no requester is starved.
- Withdraw: req1 valid for 1 cycle while RUN serves req0 → req1 is never granted and no done_o[1]; the pointer then continues at 1 for the next requester.
- Async reset mid-RUN: job D=100, rst_ni low at cycle 40 → outputs 0 immediately, no done_o after release, pointer = 0.
- With CNT_SCHED_ABORT_EN: D=50, abort_i at cycle 10 → aborted_o pulse at cycle 11, no done_o, next request is grantable at cycle 11.
